fifo_frame_reader: RTL and testbench

- Read-side consumer for the team's synchronous FIFOs. Drains length-prefixed frames from a show-ahead FIFO.
- Serializes each frame into an 8-bit valid/ready byte stream with an end-of-frame marker.
- Sits between the TX packet buffer and the MAC transmit path, and inserts a programmable inter-frame gap.

---
 rtl/fifo_frame_reader_pkg.sv | 19 +
 rtl/fifo_frame_reader_gap_timer.sv | 29 ++
 rtl/fifo_frame_reader.sv | 156 +++++++++++++++
 tb/tb_fifo_frame_reader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_frame_reader_pkg.sv
// Shared definitions for the FIFO frame reader: FSM encoding, header field
// position and the bytes-per-word helper.
package fifo_frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Byte length sits at the bottom of the header word; upper bits are ignored.
  localparam int unsigned HDR_LEN_LSB = 0;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/fifo_frame_reader_gap_timer.sv
// Loadable down-counter used to time the inter-frame gap.
// done is high when the current cycle is the last one of the programmed gap.
module frame_reader_gap_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  assign done = (cnt <= WIDTH'(1));

  // Load has priority; otherwise count down while enabled, saturating at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains length-prefixed frames from a show-ahead FIFO and serializes them
// into a little-endian 8-bit valid/ready stream with an end-of-frame marker,
// followed by a programmable inter-frame gap.
// Optional frame/byte counters: define FIFO_FRAME_READER_STATS_EN.
module fifo_frame_reader
  import fifo_frame_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err_len_zero
`ifdef FIFO_FRAME_READER_STATS_EN
  ,
  output logic [31:0]           frame_cnt,
  output logic [31:0]           byte_cnt
`endif
);

  localparam int unsigned BYTES = bytes_per_word(DATA_WIDTH);
  localparam int unsigned IDX_W = $clog2(BYTES);
  localparam int unsigned GAP_W = (IFG_CYCLES < 2) ? 1 : $clog2(IFG_CYCLES + 1);

  state_t                  state, state_n;
  logic [DATA_WIDTH-1:0]   word, word_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [LEN_WIDTH-1:0]    rem, rem_n;
  logic [LEN_WIDTH-1:0]    hdr_len;
  logic                    valid_n;
  logic                    err_n;
  logic                    gap_load;
  logic                    gap_done;
  logic                    hs;

  assign hdr_len = fifo_dout[HDR_LEN_LSB +: LEN_WIDTH];
  assign hs      = m_valid & m_ready;
  assign m_data  = word[{idx, 3'b000} +: 8];
  assign m_last  = m_valid & (rem == LEN_WIDTH'(1));
  assign busy    = (state != ST_IDLE);

  frame_reader_gap_timer #(
    .WIDTH (GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (GAP_W'(IFG_CYCLES)),
    .en       (state == ST_GAP),
    .done     (gap_done)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      word         <= '0;
      idx          <= '0;
      rem          <= '0;
      m_valid      <= 1'b0;
      err_len_zero <= 1'b0;
    end else begin
      state        <= state_n;
      word         <= word_n;
      idx          <= idx_n;
      rem          <= rem_n;
      m_valid      <= valid_n;
      err_len_zero <= err_n;
    end
  end

  // Next-state, FIFO pop and stream control.
  always_comb begin
    state_n  = state;
    word_n   = word;
    idx_n    = idx;
    rem_n    = rem;
    valid_n  = m_valid;
    err_n    = 1'b0;
    gap_load = 1'b0;
    fifo_ren = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_ren = 1'b1;
          rem_n    = hdr_len;
          if (hdr_len != '0) state_n = ST_LOAD;
          else               err_n   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!fifo_empty) begin
          fifo_ren = 1'b1;
          word_n   = fifo_dout;
          idx_n    = '0;
          valid_n  = 1'b1;
          state_n  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (hs) begin
          rem_n = rem - LEN_WIDTH'(1);
          idx_n = idx + IDX_W'(1);
          if (rem == LEN_WIDTH'(1)) begin
            // Tail bytes of the final word are dropped; that word is already popped.
            valid_n = 1'b0;
            idx_n   = '0;
            if (IFG_CYCLES > 0) begin
              state_n  = ST_GAP;
              gap_load = 1'b1;
            end else begin
              state_n = ST_IDLE;
            end
          end else if (idx == IDX_W'(BYTES - 1)) begin
            // Reload in the same cycle when possible so the stream has no bubble.
            idx_n = '0;
            if (!fifo_empty) begin
              fifo_ren = 1'b1;
              word_n   = fifo_dout;
            end else begin
              valid_n = 1'b0;
              state_n = ST_LOAD;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

`ifdef FIFO_FRAME_READER_STATS_EN
  // Frame and byte counters, advanced on stream handshakes; wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      byte_cnt  <= '0;
    end else if (hs) begin
      byte_cnt <= byte_cnt + 32'd1;
      if (m_last) frame_cnt <= frame_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed self-checking bench for fifo_frame_reader.
// Two instances share one FIFO word store with separate read pointers:
// index 0 uses IFG_CYCLES=12, index 1 uses IFG_CYCLES=0.
// Stats ports are checked when FIFO_FRAME_READER_STATS_EN is defined.
module tb_fifo_frame_reader;

  localparam int unsigned DW = 32;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          m_ready;

  logic [DW-1:0] mem [0:255];
  logic [7:0]    wp = '0;
  logic [7:0]    rp [2] = '{8'd0, 8'd0};

  logic [DW-1:0] fifo_dout [2];
  logic          fifo_empty [2];
  logic          fifo_ren [2];
  logic [7:0]    m_data [2];
  logic          m_valid [2];
  logic          m_last [2];
  logic          busy [2];
  logic          err [2];
`ifdef FIFO_FRAME_READER_STATS_EN
  logic [31:0]   frame_cnt [2];
  logic [31:0]   byte_cnt [2];
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pops [2] = '{0, 0};
  int bad_pop = 0;
  int mn [2] = '{0, 0};
  logic [7:0] mb [2][256];
  logic       ml [2][256];
  int         mc [2][256];
  int errs [2] = '{0, 0};
  int hold_bad [2] = '{0, 0};
  int busy_fall [2] = '{0, 0};
  logic       prev_wait [2] = '{1'b0, 1'b0};
  logic       prev_last [2] = '{1'b0, 1'b0};
  logic       prev_busy [2] = '{1'b0, 1'b0};
  logic [7:0] prev_data [2] = '{8'd0, 8'd0};

  // Expected byte streams of tests 1..5, concatenated.
  logic [7:0] exp_b [0:27] = '{
    8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
    8'hAA, 8'hBB,
    8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
    8'hAA, 8'hBB, 8'hCC, 8'hDD,
    8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hAA, 8'hBB, 8'hCC
  };

  int base [2];
  int pbase [2];
  int ebase [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    assign fifo_empty[g] = (rp[g] == wp);
    assign fifo_dout[g]  = mem[rp[g]];
  end

  fifo_frame_reader #(.DATA_WIDTH(32), .IFG_CYCLES(12), .LEN_WIDTH(16)) dut_a (
    .clk (clk), .rst_n (rst_n),
    .fifo_dout (fifo_dout[0]), .fifo_empty (fifo_empty[0]), .fifo_ren (fifo_ren[0]),
    .m_data (m_data[0]), .m_valid (m_valid[0]), .m_ready (m_ready), .m_last (m_last[0]),
    .busy (busy[0]), .err_len_zero (err[0])
`ifdef FIFO_FRAME_READER_STATS_EN
    , .frame_cnt (frame_cnt[0]), .byte_cnt (byte_cnt[0])
`endif
  );

  fifo_frame_reader #(.DATA_WIDTH(32), .IFG_CYCLES(0), .LEN_WIDTH(16)) dut_b (
    .clk (clk), .rst_n (rst_n),
    .fifo_dout (fifo_dout[1]), .fifo_empty (fifo_empty[1]), .fifo_ren (fifo_ren[1]),
    .m_data (m_data[1]), .m_valid (m_valid[1]), .m_ready (m_ready), .m_last (m_last[1]),
    .busy (busy[1]), .err_len_zero (err[1])
`ifdef FIFO_FRAME_READER_STATS_EN
    , .frame_cnt (frame_cnt[1]), .byte_cnt (byte_cnt[1])
`endif
  );

  // FIFO read side: pops advance the read pointer; reset flushes the FIFO.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp[0] <= wp;
      rp[1] <= wp;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (fifo_ren[d]) begin
          if (fifo_empty[d]) bad_pop <= bad_pop + 1;
          else begin
            rp[d]   <= rp[d] + 8'd1;
            pops[d] <= pops[d] + 1;
          end
        end
      end
    end
  end

  // Cycle stamp.
  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor: log handshakes, count error pulses, check hold-while-stalled.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_valid[d] && m_ready && mn[d] < 256) begin
        mb[d][mn[d]] = m_data[d];
        ml[d][mn[d]] = m_last[d];
        mc[d][mn[d]] = cyc;
        mn[d]++;
      end
      if (err[d]) errs[d]++;
      if (rst_n && prev_wait[d] &&
          (!m_valid[d] || m_data[d] != prev_data[d] || m_last[d] != prev_last[d]))
        hold_bad[d]++;
      prev_wait[d] = rst_n && m_valid[d] && !m_ready;
      prev_data[d] = m_data[d];
      prev_last[d] = m_last[d];
      if (prev_busy[d] && !busy[d]) busy_fall[d] = cyc;
      prev_busy[d] = busy[d];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wp] = w;
    wp = wp + 8'd1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(rp[0] == wp && rp[1] == wp && !busy[0] && !busy[1]) && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles, required idle", k);
    end
    tick(2);
  endtask

  task automatic mark();
    for (int d = 0; d < 2; d++) begin
      base[d]  = mn[d];
      pbase[d] = pops[d];
      ebase[d] = errs[d];
    end
  endtask

  // Compare logged bytes of one instance against exp_b[off +: n].
  task automatic check_bytes(input int d, input int off, input int n, input int mid_last);
    check($sformatf("d%0d_count_t%0d", d, off), mn[d] - base[d], n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("d%0d_byte%0d", d, off + i), mb[d][base[d] + i], exp_b[off + i]);
      check($sformatf("d%0d_last%0d", d, off + i), ml[d][base[d] + i],
            (i == n - 1 || i == mid_last) ? 1 : 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    m_ready = 1'b1;

    // Reset state
    tick(3);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_valid%0d", d), m_valid[d], 0);
      check($sformatf("rst_last%0d", d), m_last[d], 0);
      check($sformatf("rst_busy%0d", d), busy[d], 0);
      check($sformatf("rst_err%0d", d), err[d], 0);
      check($sformatf("rst_ren%0d", d), fifo_ren[d], 0);
      check($sformatf("rst_data%0d", d), m_data[d], 0);
    end
    rst_n = 1'b1;
    tick(2);

    // Test 1: len=6 over two words, full throughput, gap timing
    mark();
    push(32'd6); push(32'h44332211); push(32'h00006655);
    wait_idle(200);
    for (int d = 0; d < 2; d++) begin
      check_bytes(d, 0, 6, -1);
      check($sformatf("t1_span%0d", d), mc[d][base[d] + 5] - mc[d][base[d]], 5);
      check($sformatf("t1_pops%0d", d), pops[d] - pbase[d], 3);
      check($sformatf("t1_gap%0d", d), busy_fall[d] - mc[d][base[d] + 5], (d == 0) ? 13 : 1);
    end

    // Test 2: zero-length header then a normal frame
    mark();
    push(32'd0); push(32'd2); push(32'h0000BBAA);
    wait_idle(200);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t2_err%0d", d), errs[d] - ebase[d], 1);
      check_bytes(d, 6, 2, -1);
      check($sformatf("t2_pops%0d", d), pops[d] - pbase[d], 3);
    end

    // Test 3: underrun stall in LOAD
    mark();
    push(32'd8);
    tick(5);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t3_busy%0d", d), busy[d], 1);
      check($sformatf("t3_valid%0d", d), m_valid[d], 0);
      check($sformatf("t3_ren%0d", d), fifo_ren[d], 0);
      check($sformatf("t3_pops_stall%0d", d), pops[d] - pbase[d], 1);
    end
    push(32'h04030201); push(32'h08070605);
    wait_idle(200);
    for (int d = 0; d < 2; d++) begin
      check_bytes(d, 8, 8, -1);
      check($sformatf("t3_span%0d", d), mc[d][base[d] + 7] - mc[d][base[d]], 7);
      check($sformatf("t3_pops%0d", d), pops[d] - pbase[d], 3);
    end

    // Test 4: backpressure, m_ready high every third cycle
    mark();
    push(32'd4); push(32'hDDCCBBAA);
    for (int i = 0; i < 18; i++) begin
      m_ready = (i % 3 == 0);
      tick(1);
    end
    m_ready = 1'b1;
    wait_idle(200);
    for (int d = 0; d < 2; d++) begin
      check_bytes(d, 16, 4, -1);
      check($sformatf("t4_span%0d", d), mc[d][base[d] + 3] - mc[d][base[d]], 9);
    end

    // Test 5: back-to-back frames len=5 and len=3
    mark();
    push(32'd5); push(32'h44332211); push(32'h00000055);
    push(32'd3); push(32'h00CCBBAA);
    wait_idle(300);
    for (int d = 0; d < 2; d++) begin
      check_bytes(d, 20, 8, 4);
      check($sformatf("t5_interframe%0d", d), mc[d][base[d] + 5] - mc[d][base[d] + 4],
            (d == 0) ? 15 : 3);
      check($sformatf("t5_pops%0d", d), pops[d] - pbase[d], 5);
    end

`ifdef FIFO_FRAME_READER_STATS_EN
    for (int d = 0; d < 2; d++) begin
      check($sformatf("frame_cnt%0d", d), frame_cnt[d], 6);
      check($sformatf("byte_cnt%0d", d), byte_cnt[d], 28);
    end
`endif

    // Test 6: asynchronous reset in the middle of DATA
    push(32'd8); push(32'h11111111); push(32'h22222222);
    begin
      int k = 0;
      while (!m_valid[0] && k < 20) begin
        tick(1);
        k++;
      end
      check("t6_valid_seen", m_valid[0], 1);
    end
    tick(1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t6_valid%0d", d), m_valid[d], 0);
      check($sformatf("t6_last%0d", d), m_last[d], 0);
      check($sformatf("t6_busy%0d", d), busy[d], 0);
      check($sformatf("t6_data%0d", d), m_data[d], 0);
      check($sformatf("t6_ren%0d", d), fifo_ren[d], 0);
`ifdef FIFO_FRAME_READER_STATS_EN
      check($sformatf("t6_frame_cnt%0d", d), frame_cnt[d], 0);
      check($sformatf("t6_byte_cnt%0d", d), byte_cnt[d], 0);
`endif
    end
    tick(3);
    rst_n = 1'b1;
    tick(3);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t6_idle_busy%0d", d), busy[d], 0);
      check($sformatf("t6_idle_valid%0d", d), m_valid[d], 0);
      check($sformatf("hold%0d", d), hold_bad[d], 0);
    end
    check("empty_pop", bad_pop, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
